// File: rtl/clk_monitor.sv
// Clock-activity and period monitor: measures mon_clk period in clk cycles and reports lock, range and loss status.
// Optional min/max period statistics are enabled by defining CLK_MONITOR_STATS_EN.
module clk_monitor #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MIN_PERIOD = 4,
  parameter int unsigned MAX_PERIOD = 1000,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             range_err,
  output logic             locked,
`ifdef CLK_MONITOR_STATS_EN
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max,
`endif
  output logic             lost
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] GAP_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, LOST} state_t;

  state_t            state;
  logic              sync1, sync2, sync3;
  logic [CNT_W-1:0]  gap;
  logic [GOOD_W-1:0] good;
  logic              mon_edge_c;
  logic              in_range_c;
  logic              timeout_c;

  assign mon_edge_c = sync2 & ~sync3;
  assign in_range_c = (gap >= CNT_W'(MIN_PERIOD)) && (gap <= CNT_W'(MAX_PERIOD));
  assign timeout_c  = (gap >= CNT_W'(TIMEOUT));

  // Synchronizer, gap counter, measurement and lock/loss FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync3        <= 1'b0;
      gap          <= '0;
      good         <= '0;
      state        <= IDLE;
      period       <= '0;
      period_valid <= 1'b0;
      range_err    <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
`ifdef CLK_MONITOR_STATS_EN
      period_min   <= GAP_MAX;
      period_max   <= '0;
`endif
    end else begin
      sync1        <= mon_clk;
      sync2        <= sync1;
      sync3        <= sync2;
      period_valid <= 1'b0;
      range_err    <= 1'b0;
      locked       <= (state == LOCKED);
      lost         <= (state == LOST);

      if (mon_edge_c)
        gap <= CNT_W'(1);
      else if (gap != GAP_MAX)
        gap <= gap + CNT_W'(1);

      case (state)
        IDLE: begin
          if (mon_edge_c) begin
            state <= ARMED;
          end else if (timeout_c) begin
            state <= LOST;
`ifdef CLK_MONITOR_STATS_EN
            period_min <= GAP_MAX;
            period_max <= '0;
`endif
          end
        end
        ARMED, LOCKED: begin
          if (mon_edge_c) begin
            period       <= gap;
            period_valid <= 1'b1;
            range_err    <= ~in_range_c;
`ifdef CLK_MONITOR_STATS_EN
            if (gap < period_min) period_min <= gap;
            if (gap > period_max) period_max <= gap;
`endif
            if (!in_range_c) begin
              good  <= '0;
              state <= ARMED;
            end else if (state == ARMED) begin
              // The measurement that brings the run to LOCK_COUNT locks
              if (good >= GOOD_W'(LOCK_COUNT - 1)) begin
                good  <= GOOD_W'(LOCK_COUNT);
                state <= LOCKED;
              end else begin
                good <= good + GOOD_W'(1);
              end
            end
          end else if (timeout_c) begin
            state <= LOST;
`ifdef CLK_MONITOR_STATS_EN
            period_min <= GAP_MAX;
            period_max <= '0;
`endif
          end
        end
        LOST: begin
          if (mon_edge_c) begin
            state <= ARMED;
            good  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_monitor.sv
// Directed self-checking bench for clk_monitor: lock, range error, loss, reset and optional statistics.
module tb_clk_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        mon_clk;
  logic [15:0] period;
  logic        period_valid;
  logic        range_err;
  logic        locked;
  logic        lost;
`ifdef CLK_MONITOR_STATS_EN
  logic [15:0] period_min;
  logic [15:0] period_max;
`endif

  int ncmp = 0;
  int nfail = 0;
  int nvalid = 0;
  int nerr = 0;
  int cyc = 0;
  int valid_cyc = 0;
  int lost_cyc = 0;
  logic prev_lost = 1'b0;
  logic [15:0] last_period = '0;
  int n0;
  int w;

  clk_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .mon_clk      (mon_clk),
    .period       (period),
    .period_valid (period_valid),
    .range_err    (range_err),
    .locked       (locked),
`ifdef CLK_MONITOR_STATS_EN
    .period_min   (period_min),
    .period_max   (period_max),
`endif
    .lost         (lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe pulses away from the active edge
  always @(negedge clk) begin
    if (period_valid) begin
      nvalid++;
      last_period = period;
      valid_cyc = cyc;
    end
    if (range_err) nerr++;
    if (lost && !prev_lost) lost_cyc = cyc;
    prev_lost = lost;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One mon_clk period of n clk cycles, starting with its rising edge
  task automatic mon(input int n);
    mon_clk = 1'b1;
    repeat (n / 2) tick();
    mon_clk = 1'b0;
    repeat (n - n / 2) tick();
  endtask

  task automatic mons(input int n, input int k);
    repeat (k) mon(n);
  endtask

  task automatic wait_lost();
    w = 0;
    while (!lost && w < 2300) begin
      tick();
      w++;
    end
  endtask

  initial begin
    rst = 1'b1;
    mon_clk = 1'b0;
    repeat (3) tick();
    check("rst_period", 32'(period), 0);
    check("rst_valid", 32'(period_valid), 0);
    check("rst_range_err", 32'(range_err), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_lost", 32'(lost), 0);
    rst = 1'b0;
    tick();

    // Steady 10-cycle clock locks after the 4th measurement
    mons(10, 4);
    check("t1_valid3", 32'(nvalid), 3);
    check("t1_unlocked", 32'(locked), 0);
    mon(10);
    check("t1_valid4", 32'(nvalid), 4);
    check("t1_period", 32'(last_period), 10);
    check("t1_locked", 32'(locked), 1);
    check("t1_no_err", 32'(nerr), 0);

    // One short period breaks lock, four good periods relock
    mon(2);
    mon(10);
    check("t2_err", 32'(nerr), 1);
    check("t2_period", 32'(last_period), 2);
    check("t2_unlocked", 32'(locked), 0);
    mons(10, 3);
    check("t2_still_unlocked", 32'(locked), 0);
    mon(10);
    check("t2_relocked", 32'(locked), 1);
    check("t2_period10", 32'(last_period), 10);
    check("t2_err_once", 32'(nerr), 1);

    // Stuck clock times out into LOST
    wait_lost();
    tick();
    check("t3_lost", 32'(lost), 1);
    check("t3_lost_latency", 32'(lost_cyc - valid_cyc), 2049);
    check("t3_unlocked", 32'(locked), 0);
    check("t3_period_held", 32'(period), 10);
    n0 = nvalid;
    mon(10);
    check("t3_arm_no_valid", 32'(nvalid), 32'(n0));
    check("t3_lost_cleared", 32'(lost), 0);
    mons(10, 3);
    check("t3_unlocked_3", 32'(locked), 0);
    mon(10);
    check("t3_relocked", 32'(locked), 1);

    // Over-long periods flag every measurement and never lock
    n0 = nerr;
    mons(1200, 4);
    check("t4_errs", 32'(nerr - n0), 3);
    check("t4_unlocked", 32'(locked), 0);
    check("t4_period", 32'(last_period), 1200);
    check("t4_not_lost", 32'(lost), 0);

    // Reset while ARMED with three good measurements
    mons(10, 4);
    check("t5_armed", 32'(locked), 0);
    rst = 1'b1;
    #1;
    check("t5_period", 32'(period), 0);
    check("t5_valid", 32'(period_valid), 0);
    check("t5_range_err", 32'(range_err), 0);
    check("t5_locked", 32'(locked), 0);
    check("t5_lost", 32'(lost), 0);
    tick();
    rst = 1'b0;
    n0 = nvalid;
    mon(10);
    check("t5_arm_no_valid", 32'(nvalid), 32'(n0));
    mon(10);
    check("t5_first_meas", 32'(nvalid), 32'(n0 + 1));
    check("t5_good_cleared", 32'(locked), 0);
    mons(10, 3);
    check("t5_relocked", 32'(locked), 1);

`ifdef CLK_MONITOR_STATS_EN
    rst = 1'b1;
    tick();
    check("t6_rst_min", 32'(period_min), 32'hFFFF);
    check("t6_rst_max", 32'(period_max), 0);
    rst = 1'b0;
    tick();
    mon(8);
    mon(12);
    mon(9);
    mon(10);
    check("t6_min", 32'(period_min), 8);
    check("t6_max", 32'(period_max), 12);
    wait_lost();
    tick();
    check("t6_lost", 32'(lost), 1);
    check("t6_lost_min", 32'(period_min), 32'hFFFF);
    check("t6_lost_max", 32'(period_max), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
